// File: rtl/alu_iterative.sv
// Registered ALU with single-cycle logic/add/sub/slt and WIDTH-step iterative multiply and
// restoring divide engines behind a valid/ready handshake.
module alu_iterative #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data0_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [2:0]       ALUCtrl_i,
   output logic             ready_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic             zero_o
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   localparam logic [2:0] OpAnd  = 3'b000;
   localparam logic [2:0] OpOr   = 3'b001;
   localparam logic [2:0] OpAdd  = 3'b010;
   localparam logic [2:0] OpMul  = 3'b011;
   localparam logic [2:0] OpDivu = 3'b100;
   localparam logic [2:0] OpRemu = 3'b101;
   localparam logic [2:0] OpSub  = 3'b110;
   localparam logic [2:0] OpSlt  = 3'b111;

   typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  acc_q, acc_d;
   logic              rem_sel_q, rem_sel_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic              valid_q, valid_d;
   logic              zero_q, zero_d;

   logic [WIDTH-1:0]  alu_res;
   logic [WIDTH-1:0]  mul_acc;
   logic [WIDTH:0]    rem_sh;
   logic [WIDTH:0]    rem_sub;
   logic              div_ge;
   logic [WIDTH-1:0]  rem_nxt;
   logic [WIDTH-1:0]  quo_nxt;
   logic              last_step;

   assign ready_o = (state_q == StIdle);
   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign zero_o  = zero_q;

   // a_q doubles as the dividend shift register; quotient bits fill in from the bottom.
   assign mul_acc   = acc_q + (b_q[0] ? a_q : '0);
   assign rem_sh    = {acc_q, a_q[WIDTH-1]};
   assign div_ge    = (rem_sh >= {1'b0, b_q});
   assign rem_sub   = rem_sh - {1'b0, b_q};
   assign rem_nxt   = div_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
   assign quo_nxt   = {a_q[WIDTH-2:0], div_ge};
   assign last_step = (cnt_q == CntW'(1));

   always_comb begin
      alu_res = '0;
      unique case (ALUCtrl_i)
         OpAnd:  alu_res = data0_i & data1_i;
         OpOr:   alu_res = data0_i | data1_i;
         OpAdd:  alu_res = data0_i + data1_i;
         OpSub:  alu_res = data0_i - data1_i;
         OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(data0_i) < $signed(data1_i))};
         OpMul:  alu_res = '0;
         OpDivu: alu_res = '0;
         OpRemu: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      rem_sel_d = rem_sel_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      zero_d    = zero_q;

      unique case (state_q)
         StIdle: begin
            if (valid_i) begin
               if (ALUCtrl_i == OpMul || ALUCtrl_i == OpDivu || ALUCtrl_i == OpRemu) begin
                  a_d       = data0_i;
                  b_d       = data1_i;
                  acc_d     = '0;
                  cnt_d     = CntW'(WIDTH);
                  rem_sel_d = (ALUCtrl_i == OpRemu);
                  state_d   = (ALUCtrl_i == OpMul) ? StMul : StDiv;
               end else begin
                  data_d  = alu_res;
                  valid_d = 1'b1;
                  zero_d  = (alu_res == '0);
               end
            end
         end
         StMul: begin
            acc_d = mul_acc;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q - CntW'(1);
            if (last_step) begin
               data_d  = mul_acc;
               valid_d = 1'b1;
               zero_d  = (mul_acc == '0);
               state_d = StIdle;
            end
         end
         StDiv: begin
            acc_d = rem_nxt;
            a_d   = quo_nxt;
            cnt_d = cnt_q - CntW'(1);
            if (last_step) begin
               data_d  = rem_sel_q ? rem_nxt : quo_nxt;
               valid_d = 1'b1;
               zero_d  = rem_sel_q ? (rem_nxt == '0) : (quo_nxt == '0);
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         rem_sel_q <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         zero_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         rem_sel_q <= rem_sel_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         zero_q    <= zero_d;
      end
   end

endmodule

// File: tb/tb_alu_iterative.sv
// Bench for alu_iterative: 32-bit and 8-bit instances checked every cycle against a
// latency-level reference model, plus directed literal results.
module tb_alu_iterative;

   logic        clk;
   logic        rst_n;
   logic        v_in  [2];
   logic [63:0] a_in  [2];
   logic [63:0] b_in  [2];
   logic [2:0]  op_in [2];
   logic        rdy   [2];
   logic        vld   [2];
   logic        zr    [2];
   logic [31:0] d32;
   logic [7:0]  d8;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: edges left until a multi-cycle result lands.
   int          m_left [2];
   logic        m_v    [2];
   logic [63:0] m_d    [2];
   logic [63:0] m_pend [2];
   logic        m_z    [2];
   logic        m_acc  [2];

   alu_iterative #(.WIDTH(32)) u_alu32 (
      .clk_i    (clk),
      .rst_i    (rst_n),
      .valid_i  (v_in[0]),
      .data0_i  (a_in[0][31:0]),
      .data1_i  (b_in[0][31:0]),
      .ALUCtrl_i(op_in[0]),
      .ready_o  (rdy[0]),
      .valid_o  (vld[0]),
      .data_o   (d32),
      .zero_o   (zr[0])
   );

   alu_iterative #(.WIDTH(8)) u_alu8 (
      .clk_i    (clk),
      .rst_i    (rst_n),
      .valid_i  (v_in[1]),
      .data0_i  (a_in[1][7:0]),
      .data1_i  (b_in[1][7:0]),
      .ALUCtrl_i(op_in[1]),
      .ready_o  (rdy[1]),
      .valid_o  (vld[1]),
      .data_o   (d8),
      .zero_o   (zr[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int wid(input int i);
      return (i == 0) ? 32 : 8;
   endfunction

   function automatic logic [63:0] dout(input int i);
      return (i == 0) ? {32'b0, d32} : {56'b0, d8};
   endfunction

   function automatic logic is_multi(input logic [2:0] op);
      return (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
   endfunction

   function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [63:0] a_raw,
                                          input logic [63:0] b_raw, input int w);
      logic [63:0]        mask, a, b, r;
      logic signed [63:0] sa, sb;
      mask = (64'd1 << w) - 64'd1;
      a    = a_raw & mask;
      b    = b_raw & mask;
      sa   = $signed(a << (64 - w)) >>> (64 - w);
      sb   = $signed(b << (64 - w)) >>> (64 - w);
      case (op)
         3'b000:  r = a & b;
         3'b001:  r = a | b;
         3'b010:  r = a + b;
         3'b110:  r = a - b;
         3'b011:  r = a * b;
         3'b100:  r = (b == 0) ? mask : a / b;
         3'b101:  r = (b == 0) ? a : a % b;
         default: r = (sa < sb) ? 64'd1 : 64'd0;
      endcase
      return r & mask;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_left[i] <= 0;
            m_v[i]    <= 1'b0;
            m_d[i]    <= '0;
            m_pend[i] <= '0;
            m_z[i]    <= 1'b1;
            m_acc[i]  <= 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            int          left;
            logic        v;
            logic        acc;
            logic [63:0] d;
            logic [63:0] r;
            left = m_left[i];
            v    = 1'b0;
            acc  = 1'b0;
            d    = m_d[i];
            r    = ref_op(op_in[i], a_in[i], b_in[i], wid(i));
            if (left > 0) begin
               left--;
               if (left == 0) begin
                  v = 1'b1;
                  d = m_pend[i];
               end
            end
            if (m_left[i] == 0 && v_in[i]) begin
               acc = 1'b1;
               if (is_multi(op_in[i])) begin
                  left = wid(i);
                  m_pend[i] <= r;
               end else begin
                  v = 1'b1;
                  d = r;
               end
            end
            m_left[i] <= left;
            m_v[i]    <= v;
            m_d[i]    <= d;
            m_acc[i]  <= acc;
            if (v) m_z[i] <= (d == 0);
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("ready[%0d]", i), {63'b0, rdy[i]}, {63'b0, (m_left[i] == 0)});
         chk($sformatf("valid[%0d]", i), {63'b0, vld[i]}, {63'b0, m_v[i]});
         chk($sformatf("data[%0d]", i), dout(i), m_d[i]);
         chk($sformatf("zero[%0d]", i), {63'b0, zr[i]}, {63'b0, m_z[i]});
      end
   end

   // Presents a request and holds it until the edge at which it is accepted.
   task automatic issue(input int i, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b);
      logic ok;
      @(negedge clk);
      v_in[i]  = 1'b1;
      op_in[i] = op;
      a_in[i]  = a;
      b_in[i]  = b;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk);
         #1;
         if (m_acc[i]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic drop(input int i);
      @(negedge clk);
      v_in[i]  = 1'b0;
      op_in[i] = 3'($urandom_range(0, 7));
      a_in[i]  = {$urandom, $urandom};
      b_in[i]  = {$urandom, $urandom};
   endtask

   task automatic run_lit(input int i, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input logic exp_z,
                          input string nm);
      int lat;
      issue(i, op, a, b);
      lat = 0;
      drop(i);
      if (!vld[i]) lat = 1;
      while (!vld[i] && lat < 200) begin
         @(posedge clk);
         #1;
         if (!vld[i]) lat++;
      end
      chk({nm, "_data"}, dout(i), exp);
      chk({nm, "_zero"}, {63'b0, zr[i]}, {63'b0, exp_z});
      chk({nm, "_latency"}, 64'(lat), is_multi(op) ? 64'(wid(i)) : 64'd0);
   endtask

   initial begin
      logic [63:0] ra, rb;
      logic [2:0]  rop;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         v_in[i]  = 1'b0;
         op_in[i] = 3'b000;
         a_in[i]  = '0;
         b_in[i]  = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_ready", {63'b0, rdy[i]}, 64'd1);
         chk("rst_valid", {63'b0, vld[i]}, 64'd0);
         chk("rst_data", dout(i), 64'd0);
         chk("rst_zero", {63'b0, zr[i]}, 64'd1);
      end
      @(negedge clk);
      rst_n = 1'b1;

      run_lit(0, 3'b010, 64'hFFFF_FFFF, 64'd1, 64'd0, 1'b1, "add_wrap");
      run_lit(0, 3'b110, 64'd5, 64'd7, 64'hFFFF_FFFE, 1'b0, "sub");
      run_lit(0, 3'b111, 64'hFFFF_FFFF, 64'd1, 64'd1, 1'b0, "slt");
      run_lit(0, 3'b000, 64'hF0F0, 64'h0FF0, 64'h00F0, 1'b0, "and");
      run_lit(0, 3'b001, 64'hF0F0, 64'h0FF0, 64'hFFF0, 1'b0, "or");
      run_lit(0, 3'b011, 64'd12345, 64'd6789, 64'd83810205, 1'b0, "mul");
      run_lit(0, 3'b011, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd1, 1'b0, "mul_ones");
      run_lit(0, 3'b100, 64'd100, 64'd7, 64'd14, 1'b0, "divu");
      run_lit(0, 3'b101, 64'd100, 64'd7, 64'd2, 1'b0, "remu");
      run_lit(0, 3'b100, 64'd9, 64'd0, 64'hFFFF_FFFF, 1'b0, "divu_by0");
      run_lit(0, 3'b101, 64'd9, 64'd0, 64'd9, 1'b0, "remu_by0");
      run_lit(1, 3'b011, 64'd16, 64'd16, 64'd0, 1'b1, "mul8");
      run_lit(1, 3'b100, 64'd255, 64'd16, 64'd15, 1'b0, "divu8");
      run_lit(1, 3'b101, 64'd255, 64'd16, 64'd15, 1'b0, "remu8");

      // Back-to-back single-cycle ops, then an ADD held across a MUL.
      issue(0, 3'b010, 64'hFFFF_FFFF, 64'd1);
      issue(0, 3'b110, 64'd5, 64'd7);
      issue(0, 3'b111, 64'hFFFF_FFFF, 64'd1);
      issue(0, 3'b000, 64'hF0F0, 64'h0FF0);
      issue(0, 3'b001, 64'hF0F0, 64'h0FF0);
      issue(0, 3'b011, 64'd12345, 64'd6789);
      issue(0, 3'b010, 64'd40, 64'd2);
      drop(0);
      repeat (3) @(posedge clk);

      // Reset mid-divide: outputs return to reset values at once.
      issue(0, 3'b100, 64'd1000, 64'd3);
      drop(0);
      repeat (9) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_ready", {63'b0, rdy[0]}, 64'd1);
      chk("abort_valid", {63'b0, vld[0]}, 64'd0);
      chk("abort_data", dout(0), 64'd0);
      chk("abort_zero", {63'b0, zr[0]}, 64'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_lit(0, 3'b100, 64'd50, 64'd5, 64'd10, 1'b0, "divu_after_rst");

      for (int n = 0; n < 140; n++) begin
         int i;
         i   = (n < 70) ? 0 : 1;
         rop = 3'($urandom_range(0, 7));
         ra  = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0:       rb = 64'd0;
            1:       rb = 64'($urandom_range(1, 20));
            default: rb = {$urandom, $urandom};
         endcase
         issue(i, rop, ra, rb);
         if ($urandom_range(0, 1) == 1) begin
            drop(i);
            repeat ($urandom_range(0, 2)) @(posedge clk);
         end
      end
      drop(0);
      drop(1);
      repeat (40) @(posedge clk);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
